// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants, types and helpers for the I2S codec port.
//   SLOT_BITS / FRAME_BITS : slot and frame length in BCLK periods
//   BC_W / SLOT_IDX_W      : widths of the frame bit counter and the in-slot position
//   stereo_pair_t          : left/right pair held in full slot width (sample right-aligned)
//   slot_bit()             : serial bit for a given in-slot position (standard I2S placement)
package i2s_pkg;

    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;
    localparam int BC_W       = $clog2(FRAME_BITS);
    localparam int SLOT_IDX_W = $clog2(SLOT_BITS);

    typedef struct packed {
        logic [SLOT_BITS-1:0] left;
        logic [SLOT_BITS-1:0] right;
    } stereo_pair_t;

    // Slot position 0 is the one-bit I2S delay (padding); positions 1..width
    // carry the sample MSB first; anything after that is zero.
    function automatic logic slot_bit(input logic [SLOT_BITS-1:0]  sample,
                                      input logic [SLOT_IDX_W-1:0] slot_pos,
                                      input int                    width);
        logic [SLOT_IDX_W-1:0] idx;
        idx = SLOT_IDX_W'(width - int'(slot_pos));
        if (slot_pos != '0 && int'(slot_pos) <= width) return sample[idx];
        return 1'b0;
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: MCLK/BCLK dividers and the I2S frame bit counter.
//   clock, reset : system clock, synchronous active-high reset
//   mclk         : free-running master clock, toggles every MCLK_DIV cycles
//   bclk         : bit clock, toggles every BCLK_DIV cycles
//   fall_stb     : high in the cycle whose closing edge drives bclk 1->0
//   rise_stb     : high in the cycle whose closing edge drives bclk 0->1
//   bc           : frame bit counter 0..63, advances with each bclk fall
// The strobes are decoded from the divider counters so that the parent's
// registers change on the very same clock edge as bclk itself.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int BCLK_DIV = 4,
    parameter int MCLK_DIV = 1
) (
    input  logic            clock,
    input  logic            reset,
    output logic            mclk,
    output logic            bclk,
    output logic            fall_stb,
    output logic            rise_stb,
    output logic [BC_W-1:0] bc
);

    localparam int BCNT_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int MCNT_W = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BCLK_DIV - 1);
    localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(MCLK_DIV - 1);

    logic [BCNT_W-1:0] bcnt;
    logic [MCNT_W-1:0] mcnt;
    logic              bwrap;
    logic              mwrap;

    assign bwrap    = (bcnt == BCNT_LAST);
    assign mwrap    = (mcnt == MCNT_LAST);
    assign fall_stb = bwrap &&  bclk;
    assign rise_stb = bwrap && !bclk;

    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values; blocking assignments here would create ordering races.
    always_ff @(posedge clock) begin
        if (reset) begin
            bcnt <= '0;
            bclk <= 1'b0;
            bc   <= '1;           // 63: the first bclk fall wraps to 0 and starts a frame
        end else if (bwrap) begin
            bcnt <= '0;
            bclk <= ~bclk;
            if (bclk) bc <= bc + 1'b1;
        end else begin
            bcnt <= bcnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mcnt <= '0;
            mclk <= 1'b0;
        end else if (mwrap) begin
            mcnt <= '0;
            mclk <= ~mclk;
        end else begin
            mcnt <= mcnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_codec_port.sv
// i2s_codec_port: stereo I2S master between the sample path and codec pins.
//   clock, reset                : system clock, synchronous active-high reset
//   tx_left/tx_right/tx_valid   : playback pair offered; tx_ready = holding register empty
//   tx_underrun                 : one-cycle pulse when a frame starts with nothing held
//   rx_left/rx_right/rx_valid   : captured codec pair, rx_valid pulses once per frame
//   pattern_error               : sticky loopback-pattern error (0 unless I2S_TEST_PATTERN_EN)
//   MCLK, BCLK, LRCLK, DOUT     : I2S master outputs (all registered)
//   DIN                         : codec serial data
// Build option: define I2S_TEST_PATTERN_EN to replace TX data with a
// per-frame counter pattern (left = n, right = ~n) and check it on RX.
module i2s_codec_port
    import i2s_pkg::*;
#(
    parameter int WIDTH    = 24,
    parameter int BCLK_DIV = 4,
    parameter int MCLK_DIV = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] tx_left,
    input  logic [WIDTH-1:0] tx_right,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_underrun,
    output logic [WIDTH-1:0] rx_left,
    output logic [WIDTH-1:0] rx_right,
    output logic             rx_valid,
    output logic             pattern_error,
    output logic             MCLK,
    output logic             BCLK,
    output logic             LRCLK,
    output logic             DOUT,
    input  logic             DIN
);

    logic                  fall_stb;
    logic                  rise_stb;
    logic [BC_W-1:0]       bc;
    logic [BC_W-1:0]       next_bc;
    logic                  frame_start;
    logic [SLOT_IDX_W-1:0] rx_pos;
    logic                  rx_capture;

    stereo_pair_t          hold;
    logic                  hold_empty;
    stereo_pair_t          tx_frame;
    stereo_pair_t          load_pair;
    logic                  accept;
    logic [WIDTH-1:0]      rx_sh_l;
    logic [WIDTH-1:0]      rx_sh_r;

    i2s_clkgen #(
        .BCLK_DIV (BCLK_DIV),
        .MCLK_DIV (MCLK_DIV)
    ) u_clkgen (
        .clock    (clock),
        .reset    (reset),
        .mclk     (MCLK),
        .bclk     (BCLK),
        .fall_stb (fall_stb),
        .rise_stb (rise_stb),
        .bc       (bc)
    );

    assign next_bc     = bc + 1'b1;
    assign frame_start = fall_stb && (bc == BC_W'(FRAME_BITS - 1));
    assign tx_ready    = hold_empty;
    assign accept      = tx_valid && hold_empty;

    // DIN is taken on the bclk rise inside the bit period whose slot
    // position (bc within the slot) falls in 1..WIDTH.
    assign rx_pos     = bc[SLOT_IDX_W-1:0];
    assign rx_capture = rise_stb && (rx_pos != '0) && (int'(rx_pos) <= WIDTH);

`ifdef I2S_TEST_PATTERN_EN
    logic [WIDTH-1:0] pat_n;
    logic [WIDTH-1:0] pat_inv;
    logic [WIDTH-1:0] pat_exp;
    logic             rx_seen;
    logic             pat_seeded;
    logic             pat_err;

    assign pat_inv = ~pat_n;
`endif

    // NOTE: load_pair gets a full default before any condition, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        load_pair = '0;
`ifdef I2S_TEST_PATTERN_EN
        // The pattern is sent every frame, held pair or not; the handshake
        // and underrun reporting still run on the holding register.
        load_pair.left  = SLOT_BITS'(pat_n);
        load_pair.right = SLOT_BITS'(pat_inv);
`else
        if (!hold_empty) load_pair = hold;
`endif
    end

    // NOTE: the data registers (hold, shift and capture) are reset as well,
    // because a mid-frame reset must discard in-flight samples, not replay them.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold        <= '0;
            hold_empty  <= 1'b1;
            tx_frame    <= '0;
            tx_underrun <= 1'b0;
            LRCLK       <= 1'b1;
            DOUT        <= 1'b0;
            rx_sh_l     <= '0;
            rx_sh_r     <= '0;
            rx_left     <= '0;
            rx_right    <= '0;
            rx_valid    <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            rx_valid    <= 1'b0;

            if (accept) begin
                hold.left  <= SLOT_BITS'(tx_left);
                hold.right <= SLOT_BITS'(tx_right);
                hold_empty <= 1'b0;
            end

            if (frame_start) begin
                tx_frame    <= load_pair;
                tx_underrun <= hold_empty;
                // Only a full register is emptied: a pair accepted on this
                // same edge must stay held for the following frame.
                if (!hold_empty) hold_empty <= 1'b1;
                rx_left  <= rx_sh_l;
                rx_right <= rx_sh_r;
                rx_valid <= 1'b1;
            end

            if (fall_stb) begin
                LRCLK <= next_bc[BC_W-1];
                // At frame start tx_frame is being reloaded; slot bit 0 is padding anyway.
                if (frame_start) DOUT <= 1'b0;
                else DOUT <= slot_bit(next_bc[BC_W-1] ? tx_frame.right : tx_frame.left,
                                      next_bc[SLOT_IDX_W-1:0], WIDTH);
            end

            if (rx_capture) begin
                if (bc[BC_W-1]) rx_sh_r <= {rx_sh_r[WIDTH-2:0], DIN};
                else            rx_sh_l <= {rx_sh_l[WIDTH-2:0], DIN};
            end
        end
    end

`ifdef I2S_TEST_PATTERN_EN
    // The first capture after reset is a partial frame and is not checked;
    // the predicted counter seeds from the first complete left sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            pat_n      <= '0;
            pat_exp    <= '0;
            rx_seen    <= 1'b0;
            pat_seeded <= 1'b0;
            pat_err    <= 1'b0;
        end else if (frame_start) begin
            pat_n <= pat_n + 1'b1;
            if (!rx_seen) begin
                rx_seen <= 1'b1;
            end else begin
                if (rx_sh_r != ~rx_sh_l)              pat_err <= 1'b1;
                if (pat_seeded && rx_sh_l != pat_exp) pat_err <= 1'b1;
                pat_exp    <= (pat_seeded ? pat_exp : rx_sh_l) + 1'b1;
                pat_seeded <= 1'b1;
            end
        end
    end

    assign pattern_error = pat_err;
`else
    assign pattern_error = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_codec_port.sv
// tb_i2s_codec_port: self-checking bench for i2s_codec_port with DOUT looped
// back to DIN. Directed frames push the pair each frame carries into a
// scoreboard queue; a monitor pops and compares on every rx_valid.
module tb_i2s_codec_port;

    localparam int WIDTH     = 24;
    localparam int BCLK_DIV  = 4;
    localparam int MCLK_DIV  = 1;
    localparam int BIT_CYC   = 2 * BCLK_DIV;
    localparam int FRAME_CYC = 64 * BIT_CYC;

    typedef struct packed {
        logic [WIDTH-1:0] l;
        logic [WIDTH-1:0] r;
    } pair_t;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] tx_left = '0;
    logic [WIDTH-1:0] tx_right = '0;
    logic             tx_valid = 1'b0;
    logic             tx_ready;
    logic             tx_underrun;
    logic [WIDTH-1:0] rx_left;
    logic [WIDTH-1:0] rx_right;
    logic             rx_valid;
    logic             pattern_error;
    logic             mclk, bclk, lrclk, dout, din;
    logic             din_flip = 1'b0;

    int total = 0;
    int bad   = 0;
    int under_cnt = 0;

    assign din = dout ^ din_flip;

    always #5 clock = ~clock;

    i2s_codec_port #(
        .WIDTH    (WIDTH),
        .BCLK_DIV (BCLK_DIV),
        .MCLK_DIV (MCLK_DIV)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .tx_left       (tx_left),
        .tx_right      (tx_right),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_underrun   (tx_underrun),
        .rx_left       (rx_left),
        .rx_right      (rx_right),
        .rx_valid      (rx_valid),
        .pattern_error (pattern_error),
        .MCLK          (mclk),
        .BCLK          (bclk),
        .LRCLK         (lrclk),
        .DOUT          (dout),
        .DIN           (din)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string name);
        check({name, " MCLK"},          64'(mclk),          0);
        check({name, " BCLK"},          64'(bclk),          0);
        check({name, " LRCLK"},         64'(lrclk),         1);
        check({name, " DOUT"},          64'(dout),          0);
        check({name, " tx_ready"},      64'(tx_ready),      1);
        check({name, " tx_underrun"},   64'(tx_underrun),   0);
        check({name, " rx_left"},       64'(rx_left),       0);
        check({name, " rx_right"},      64'(rx_right),      0);
        check({name, " rx_valid"},      64'(rx_valid),      0);
        check({name, " pattern_error"}, 64'(pattern_error), 0);
    endtask

    // Called at the negedge where reset has just been released; returns at the
    // negedge after the first BCLK fall (the first frame start).
    task automatic first_frame(input string name);
        int rise_at = -1;
        int fall_at = -1;
        for (int k = 1; k <= 4 * BIT_CYC; k++) begin
            @(negedge clock);
            if (k == 1) check({name, " MCLK first toggle"}, 64'(mclk), 1);
            if (k == BIT_CYC - 1) check({name, " LRCLK before start"}, 64'(lrclk), 1);
            if (bclk && rise_at < 0) rise_at = k;
            if (!bclk && rise_at >= 0) begin
                fall_at = k;
                break;
            end
        end
        check({name, " BCLK first rise"}, 64'(rise_at), 64'(BCLK_DIV));
        check({name, " BCLK first fall"}, 64'(fall_at), 64'(2 * BCLK_DIV));
    endtask

    always @(negedge clock) if (!reset && tx_underrun) under_cnt++;

`ifndef I2S_TEST_PATTERN_EN
    localparam logic [1:0] OFFER_NONE  = 2'd0;
    localparam logic [1:0] OFFER_EARLY = 2'd1;
    localparam logic [1:0] OFFER_LATE  = 2'd2;

    pair_t exp_q[$];
    pair_t mon_e;
    int    rx_cnt = 0;

    always @(negedge clock) begin
        if (!reset && rx_valid) begin
            rx_cnt++;
            check("rx expected pair queued", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("rx_left", 64'(rx_left), 64'(mon_e.l));
                check("rx_right", 64'(rx_right), 64'(mon_e.r));
            end
        end
    end

    // Expected serial frame indexed by bit counter: padding bit, WIDTH bits MSB first, zeros.
    function automatic logic [63:0] exp_vec(input pair_t p);
        logic [63:0]      v;
        logic [WIDTH-1:0] smp;
        int               s;
        v = '0;
        for (int b = 0; b < 64; b++) begin
            s   = b % 32;
            smp = (b < 32) ? p.l : p.r;
            if (s >= 1 && s <= WIDTH) v[b] = smp[WIDTH-s];
        end
        return v;
    endfunction

    // Entered at the negedge right after a frame-start edge, returns at the
    // negedge right after the next one. Early offers handshake on the first
    // edge of the frame; late offers handshake on the next frame-start edge.
    task automatic run_frame(input string name, input pair_t content, input logic exp_under,
                             input logic exp_ready, input logic [1:0] mode, input pair_t offer,
                             output logic [63:0] obs);
        check({name, " tx_underrun"}, 64'(tx_underrun), 64'(exp_under));
        check({name, " tx_ready"},    64'(tx_ready),    64'(exp_ready));
        check({name, " LRCLK left"},  64'(lrclk),       0);
        exp_q.push_back(content);
        tx_left  = offer.l;
        tx_right = offer.r;
        tx_valid = (mode == OFFER_EARLY);
        for (int b = 0; b < 64; b++) begin
            obs[b] = dout;
            for (int c = 0; c < BIT_CYC; c++) begin
                @(negedge clock);
                if (b == 0 && c == 0) begin
                    tx_valid = 1'b0;
                    if (mode == OFFER_EARLY) check({name, " offer accepted"}, 64'(tx_ready), 0);
                end
                if (mode == OFFER_LATE && b == 63 && c == BIT_CYC - 2) tx_valid = 1'b1;
            end
        end
        check({name, " DOUT frame"}, obs, exp_vec(content));
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
`ifndef I2S_TEST_PATTERN_EN
        pair_t       zero_p, pa, pb, pc, pd;
        logic [63:0] obs;
        zero_p = '0;
        pa = '{l: 24'h800001, r: 24'h7FFFFE};
        pb = '{l: 24'h123456, r: 24'hABCDEF};
        pc = '{l: 24'hFFFFFF, r: 24'h000001};
        pd = '{l: 24'h5A5A5A, r: 24'hA5A5A5};
`endif
        repeat (3) @(negedge clock);
        check_reset("reset");
        reset = 1'b0;
`ifndef I2S_TEST_PATTERN_EN
        exp_q.push_back('0);                     // partial first frame after reset
        first_frame("start");
        run_frame("f0", zero_p, 1'b1, 1'b1, OFFER_EARLY, pa, obs);
        run_frame("f1", pa,     1'b0, 1'b1, OFFER_NONE,  zero_p, obs);
        check("f1 DOUT hand vector", obs, 64'h00FF_FFFC_0100_0002);
        run_frame("f2", zero_p, 1'b1, 1'b1, OFFER_NONE,  zero_p, obs);
        run_frame("f3", zero_p, 1'b1, 1'b1, OFFER_LATE,  pb, obs);
        run_frame("f4", zero_p, 1'b1, 1'b0, OFFER_NONE,  zero_p, obs);
        run_frame("f5", pb,     1'b0, 1'b1, OFFER_EARLY, pc, obs);
        run_frame("f6", pc,     1'b0, 1'b1, OFFER_EARLY, pd, obs);

        // Frame 7 carries pd; abort it at bc=40 with a one-cycle reset.
        repeat (40 * BIT_CYC) @(negedge clock);
        check("bc40 LRCLK right", 64'(lrclk), 1);
        reset = 1'b1;
        @(negedge clock);
        check_reset("mid-frame reset");
        reset = 1'b0;
        exp_q.push_back('0);
        first_frame("restart");
        run_frame("r0", zero_p, 1'b1, 1'b1, OFFER_NONE, zero_p, obs);
        repeat (4) @(negedge clock);

        check("underrun pulse count", 64'(under_cnt), 6);
        check("rx_valid count", 64'(rx_cnt), 10);
        check("scoreboard drained", 64'(exp_q.size()), 0);
        check("pattern_error idle", 64'(pattern_error), 0);
`else
        first_frame("start");
        repeat (100 * FRAME_CYC) @(negedge clock);
        check("pattern clean 100 frames", 64'(pattern_error), 0);
        repeat (5 * BIT_CYC) @(negedge clock);
        din_flip = 1'b1;
        repeat (BIT_CYC) @(negedge clock);
        din_flip = 1'b0;
        repeat (2 * FRAME_CYC) @(negedge clock);
        check("pattern error set", 64'(pattern_error), 1);
        repeat (FRAME_CYC) @(negedge clock);
        check("pattern error sticky", 64'(pattern_error), 1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
